// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: controller states and
// the recoded partial-product select.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps {m[1], m[0], m_prev} to a partial-product select.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] bits,
    output booth_sel_t sel
);

    always_comb begin
        sel = ZERO;
        unique case (bits)
            3'b000:  sel = ZERO;
            3'b001:  sel = POS1;
            3'b010:  sel = POS1;
            3'b011:  sel = POS2;
            3'b100:  sel = NEG2;
            3'b101:  sel = NEG1;
            3'b110:  sel = NEG1;
            3'b111:  sel = ZERO;
            default: sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per request,
// with a zero-operand early-out and a registered one-cycle ready pulse.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int L_WORD = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [L_WORD-1:0]     word1,
    input  logic [L_WORD-1:0]     word2,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  ready,
    output logic [2*L_WORD-1:0]   product
);

    localparam int NITER = L_WORD / 2 + 1;
    localparam int CW    = $clog2(NITER + 1);
    localparam int XW    = L_WORD + 2;
    localparam int AW    = 2 * L_WORD + 2;

    state_t            state, state_next;
    booth_sel_t        sel;
    logic [AW-1:0]     acc, acc_next, mcand, addend;
    logic [XW-1:0]     mplier;
    logic [XW-1:0]     word1_ext, word2_ext;
    logic              m_prev;
    logic [CW-1:0]     iter;
    logic              last_iter, operand_zero, in_done;

    assign word1_ext    = signed_mode ? {{2{word1[L_WORD-1]}}, word1} : {2'b00, word1};
    assign word2_ext    = signed_mode ? {{2{word2[L_WORD-1]}}, word2} : {2'b00, word2};
    assign operand_zero = (word1 == '0) || (word2 == '0);
    assign last_iter    = (iter == CW'(NITER - 1));

    booth_r4_encoder u_encoder (
        .bits ({mplier[1:0], m_prev}),
        .sel  (sel)
    );

    always_comb begin
        addend = '0;
        unique case (sel)
            ZERO:    addend = '0;
            POS1:    addend = mcand;
            POS2:    addend = mcand << 1;
            NEG1:    addend = -mcand;
            NEG2:    addend = -(mcand << 1);
            default: addend = '0;
        endcase
    end

    assign acc_next = acc + addend;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = operand_zero ? DONE : CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy    = (state == CALC) || (state == DONE);
        in_done = (state == DONE);
    end

    // Datapath; ready is registered off DONE so it lands one cycle after entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            m_prev  <= 1'b0;
            iter    <= '0;
            product <= '0;
            ready   <= 1'b0;
        end else begin
            ready <= in_done;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{L_WORD{word1_ext[XW-1]}}, word1_ext};
                        mplier <= word2_ext;
                        m_prev <= 1'b0;
                        acc    <= '0;
                        iter   <= '0;
                        if (operand_zero) product <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 2;
                    mplier <= {{2{mplier[XW-1]}}, mplier[XW-1:2]};
                    m_prev <= mplier[1];
                    iter   <= iter + CW'(1);
                    if (last_iter) product <= acc_next[2*L_WORD-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 SHALL have parameter: L_WORD, 8, operand width in bits; even, >= 4.
REQ-002 SHALL have derived constant: NITER, L_WORD/2+1, radix-4 iterations per multiply.
REQ-003 SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: word1  input  L_WORD  multiplicand.
REQ-007 SHALL have port: word2  input  L_WORD  multiplier.
REQ-008 SHALL have port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-009 SHALL have port: busy  output  1  high in CALC and DONE.
REQ-010 SHALL have port: ready  output  1  one-cycle pulse, product valid.
REQ-011 SHALL have port: product  output  2*L_WORD  result; signed or unsigned per captured mode.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE with start=1 SHALL capture word1, word2, signed_mode and clear the accumulator on the same edge.
REQ-014 Capture SHALL extend both operands to L_WORD+2 bits: sign-extend if signed_mode=1, zero-extend otherwise.
REQ-015 If captured word1==0 or word2==0, SHALL go IDLE->DONE directly with product=0 (early-out).
REQ-016 Otherwise SHALL go IDLE->CALC and stay exactly NITER cycles.
REQ-017 Each CALC cycle SHALL recode multiplier bits {m[1],m[0],m_prev} to {0,+1,+2,-1,-2}, add or subtract the matching multiple of the multiplicand into a 2*L_WORD+2-bit accumulator, shift multiplicand left 2 and multiplier right 2 (arithmetic), and update m_prev=m[1].
REQ-018 m_prev SHALL be 0 at capture.
REQ-019 After the NITER-th CALC cycle SHALL go to DONE and load product with accumulator[2*L_WORD-1:0].
REQ-020 DONE SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-021 Latency: start at edge T gives ready high in the cycle after edge T+1+NITER (normal) or after edge T+1 (early-out).
REQ-022 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-023 start in the DONE cycle SHALL be ignored; back-to-back throughput is one result per NITER+2 cycles.
REQ-024 product SHALL hold its last value from DONE until the next DONE.
REQ-025 Operand inputs SHALL be don't-care outside the capture edge.
REQ-026 Most-negative operands (signed) and all-ones operands (unsigned) SHALL give exact results with no overflow.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, busy=0, ready=0, product=0, and clear all internal registers, including mid-CALC or in DONE.
REQ-028 reset SHALL take priority over start on the same edge.

Structure
REQ-029 Package booth_pkg SHALL hold the FSM state type and the recode-select type {ZERO,POS1,POS2,NEG1,NEG2}.
REQ-030 Recoding SHALL be a separate combinational sub-module booth_r4_encoder (3-bit group in, select out).
REQ-031 Iteration count SHALL be a single counter of width $clog2(NITER+1).

Verification (L_WORD=8, NITER=5)
REQ-032 Signed: word1=8'h80, word2=8'h80, signed_mode=1 -> ready 7 cycles after start edge, product=16'h4000.
REQ-033 Unsigned: word1=8'hFF, word2=8'hFF, signed_mode=0 -> product=16'hFE01; the same operands with signed_mode=1 -> 16'h0001.
REQ-034 Early-out: word1=8'h00, word2=8'h5A -> ready 2 cycles after start edge, product=16'h0000.
REQ-035 Busy-ignore: start 8'h03*8'h04; re-pulse start with 8'h07*8'h07 during CALC -> single ready, product=16'h000C.
REQ-036 Reset mid-op: reset asserted on the 3rd CALC cycle -> next cycle IDLE, product=0, no ready; a new start 8'hFF*8'h7F signed -> product=16'hFF81.
